// File: rtl/lif_pkg.sv
// Shared definitions for time-multiplexed LIF neuron arrays: FSM encoding and default parameters.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_N_NEURONS  = 4;
  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_THRESHOLD  = 200;
  localparam int unsigned DEF_LEAK_SHIFT = 1;
  localparam int unsigned DEF_REFRACT    = 2;

  // Refractory counter width; kept at least one bit so REFRACT=0 still yields a legal vector.
  function automatic int unsigned refr_width(input int unsigned refract);
    return (refract == 0) ? 1 : $clog2(refract + 1);
  endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational single-neuron LIF update: leak, saturating integrate, threshold, refractory hold.
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned THRESHOLD  = DEF_THRESHOLD,
  parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int unsigned REFRACT    = DEF_REFRACT,
  parameter int unsigned REFR_W     = refr_width(DEF_REFRACT)
) (
  input  logic [WIDTH-1:0]  state,
  input  logic [WIDTH-1:0]  current,
  input  logic [REFR_W-1:0] refr,
  output logic [WIDTH-1:0]  next_state,
  output logic              spike,
  output logic [REFR_W-1:0] next_refr
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sat;

  always_comb begin
    sum        = {1'b0, current} + {1'b0, state >> LEAK_SHIFT};
    sat        = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    next_state = sat;
    spike      = 1'b0;
    next_refr  = refr;
    if (refr != '0) begin
      // Silent neuron: input is ignored and the membrane is held at rest.
      next_state = '0;
      next_refr  = refr - REFR_W'(1);
    end else if (sat >= WIDTH'(THRESHOLD)) begin
      next_state = '0;
      spike      = 1'b1;
      next_refr  = REFR_W'(REFRACT);
    end
  end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// Shares one LIF update unit across N_NEURONS neurons, one neuron per cycle in a feed-forward chain.
module lif_tdm_scheduler
  import lif_pkg::*;
#(
  parameter int unsigned N_NEURONS  = DEF_N_NEURONS,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned THRESHOLD  = DEF_THRESHOLD,
  parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int unsigned REFRACT    = DEF_REFRACT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          tick,
  input  logic [WIDTH-1:0]              ext_current,
  input  logic [$clog2(N_NEURONS)-1:0]  dbg_sel,
  output logic [WIDTH-1:0]              dbg_state,
  output logic [N_NEURONS-1:0]          spikes,
  output logic                          frame_done,
  output logic                          busy,
  output logic                          overrun
);

  localparam int unsigned IDX_W  = $clog2(N_NEURONS);
  localparam int unsigned REFR_W = refr_width(REFRACT);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [WIDTH-1:0]       ext_q;
  logic [N_NEURONS-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]       mem_q  [N_NEURONS];
  logic [REFR_W-1:0]      refr_q [N_NEURONS];

  logic                   last;
  logic [WIDTH-1:0]       cur;
  logic [WIDTH-1:0]       upd_state;
  logic                   upd_spike;
  logic [REFR_W-1:0]      upd_refr;

  assign last      = (idx_q == IDX_W'(N_NEURONS - 1));
  assign dbg_state = mem_q[dbg_sel];

  // Neuron k>0 sees its predecessor's state, which was already updated earlier in this frame.
  always_comb begin
    cur   = (idx_q == '0) ? ext_q : mem_q[idx_q - IDX_W'(1)];
    acc_d = acc_q;
    acc_d[idx_q] = upd_spike;
  end

  lif_update_unit #(
    .WIDTH      (WIDTH),
    .THRESHOLD  (THRESHOLD),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACT    (REFRACT),
    .REFR_W     (REFR_W)
  ) u_update (
    .state      (mem_q[idx_q]),
    .current    (cur),
    .refr       (refr_q[idx_q]),
    .next_state (upd_state),
    .spike      (upd_spike),
    .next_refr  (upd_refr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= '0;
      ext_q      <= '0;
      acc_q      <= '0;
      spikes     <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_q[i]  <= '0;
        refr_q[i] <= '0;
      end
    end else if (ena) begin
      frame_done <= (state_d == DONE);
      busy       <= (state_d != IDLE);
      if (tick && (state_q != IDLE)) overrun <= 1'b1;
      case (state_q)
        IDLE: begin
          if (tick) begin
            ext_q <= ext_current;
            idx_q <= '0;
            acc_q <= '0;
          end
        end
        RUN: begin
          mem_q[idx_q]  <= upd_state;
          refr_q[idx_q] <= upd_refr;
          acc_q         <= acc_d;
          if (last) begin
            spikes <= acc_d;
            idx_q  <= '0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Scoreboard bench for lif_tdm_scheduler: directed frames push expectations, a monitor checks each frame_done.
module tb_lif_tdm_scheduler;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       tick;
  logic [7:0] ext_current;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_state;
  logic [3:0] spikes;
  logic       frame_done;
  logic       busy;
  logic       overrun;

  logic [1:0] sel_main;
  logic [1:0] sel_mon;
  logic       mon_owns;
  assign dbg_sel = mon_owns ? sel_mon : sel_main;

  typedef struct {
    logic [3:0]      spk;
    logic [3:0][7:0] mem;
    int              lat;
    int              tick_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   done_count;
  int   cyc;

  lif_tdm_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .tick        (tick),
    .ext_current (ext_current),
    .dbg_sel     (dbg_sel),
    .dbg_state   (dbg_state),
    .spikes      (spikes),
    .frame_done  (frame_done),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: every frame_done pops one expectation and checks spikes, latency and the register file.
  initial begin
    exp_t e;
    mon_owns = 1'b0;
    sel_mon  = '0;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        done_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("spikes", int'(spikes), int'(e.spk));
          chk("done_latency", cyc - e.tick_cyc, e.lat);
          mon_owns = 1'b1;
          for (int i = 0; i < 4; i++) begin
            sel_mon = 2'(i);
            #1;
            chk($sformatf("mem%0d", i), int'(dbg_state), int'(e.mem[i]));
          end
          mon_owns = 1'b0;
        end
      end
    end
  end

  task automatic hard_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Pulse tick for one edge; returns #1 after the sampling edge.
  task automatic start_tick(input logic [7:0] ext, input logic [3:0] spk,
                            input logic [3:0][7:0] mem, input int lat, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    ext_current = ext;
    tick        = 1'b1;
    @(posedge clk);
    #1;
    tick       = 1'b0;
    e.spk      = spk;
    e.mem      = mem;
    e.lat      = lat;
    e.tick_cyc = cyc;
    if (push) exp_q.push_back(e);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_count < target && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", int'(done_count >= target), 1);
  endtask

  task automatic frame(input logic [7:0] ext, input logic [3:0] spk, input logic [3:0][7:0] mem);
    int target;
    target = done_count + 1;
    start_tick(ext, spk, mem, 4, 1'b1);
    wait_done(target);
  endtask

  initial begin
    int base;
    checks      = 0;
    failures    = 0;
    done_count  = 0;
    rst_n       = 1'b0;
    ena         = 1'b1;
    tick        = 1'b0;
    ext_current = '0;
    sel_main    = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_spikes", int'(spikes), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    for (int i = 0; i < 4; i++) begin
      sel_main = 2'(i);
      #1;
      chk($sformatf("rst_mem%0d", i), int'(dbg_state), 0);
    end

    // Saturation and refractory on neuron 0
    frame(8'd255, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd0});
    frame(8'd255, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd0});
    frame(8'd255, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd0});
    frame(8'd255, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd0});

    // Feed-forward chain
    hard_reset();
    frame(8'd100, 4'b0000, {8'd100, 8'd100, 8'd100, 8'd100});
    frame(8'd100, 4'b0010, {8'd100, 8'd50, 8'd0, 8'd150});

    // Reset at idx==2 discards the partial frame
    base = done_count;
    start_tick(8'd100, 4'b0000, '0, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_spikes", int'(spikes), 0);
    chk("midrst_frame_done", int'(frame_done), 0);
    for (int i = 0; i < 4; i++) begin
      sel_main = 2'(i);
      #1;
      chk($sformatf("midrst_mem%0d", i), int'(dbg_state), 0);
    end
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_done", done_count, base);

    // Overrun: tick during RUN idx==1 is ignored but flagged
    base = done_count;
    start_tick(8'd100, 4'b0000, {8'd100, 8'd100, 8'd100, 8'd100}, 4, 1'b1);
    chk("overrun_before", int'(overrun), 0);
    @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    wait_done(base + 1);
    chk("overrun_set", int'(overrun), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("overrun_no_extra_frame", done_count, base + 1);
    chk("overrun_idle", int'(busy), 0);
    chk("overrun_sticky", int'(overrun), 1);

    // ena gating: 3 frozen cycles mid-RUN delay frame_done by 3
    hard_reset();
    chk("ena_overrun_cleared", int'(overrun), 0);
    frame(8'd100, 4'b0000, {8'd100, 8'd100, 8'd100, 8'd100});
    base = done_count;
    start_tick(8'd100, 4'b0010, {8'd100, 8'd50, 8'd0, 8'd150}, 7, 1'b1);
    @(posedge clk);
    #1 ena = 1'b0;
    repeat (3) @(posedge clk);
    #1 ena = 1'b1;
    wait_done(base + 1);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
